// File: rtl/accum_ctrl.sv
// accum_ctrl
//   Initiator side of the accumulator start/finish protocol. A job of length N
//   is accepted on the req_* port. The controller pulses acc_start for one
//   cycle with acc_data=N and waits for acc_finish. It then returns the
//   captured sum on the rsp_* port. If no finish arrives, a timeout returns
//   an error response with sum 0.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   req_valid/ready/len   job request handshake and job length N
//   rsp_valid/ready       result handshake
//   rsp_sum, rsp_err      captured sum, timeout flag (sum forced to 0)
//   acc_start, acc_data   start pulse and length to the accumulator
//   acc_finish, acc_sum   done pulse and sum from the accumulator
//   busy                  controller not idle
//   stray_fin             sticky: acc_finish seen outside WAIT
//   job_cnt               number of completed responses (wraps)
//
// State  | meaning
// -------+--------------------------------------------------------------
// IDLE   | ready for a job; acc_data parked at 0
// ISSUE  | single cycle with acc_start=1
// WAIT   | waiting for acc_finish; timeout counter running
// RESP   | rsp_valid=1; sum/err held until the consumer takes them
module accum_ctrl #(
    parameter int DW     = 3,
    parameter int TMO    = 15,
    parameter int TMO_W  = 4,
    parameter int JCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DW-1:0]     req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DW-1:0]     rsp_sum,
    output logic              rsp_err,
    output logic              acc_start,
    output logic [DW-1:0]     acc_data,
    input  logic              acc_finish,
    input  logic [DW-1:0]     acc_sum,
    output logic              busy,
    output logic              stray_fin,
    output logic [JCNT_W-1:0] job_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // The counter holds the number of WAIT cycles already spent. The last
    // allowed WAIT cycle sees TMO-1, so the controller spends exactly TMO
    // cycles in WAIT before it gives up.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);

    state_t              state_q, state_d;
    logic [DW-1:0]       len_q, len_d;
    logic [DW-1:0]       sum_q, sum_d;
    logic                err_q, err_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [JCNT_W-1:0]   job_cnt_q, job_cnt_d;
    logic                stray_q, stray_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            sum_q     <= '0;
            err_q     <= 1'b0;
            tmo_q     <= '0;
            job_cnt_q <= '0;
            stray_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            sum_q     <= sum_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            job_cnt_q <= job_cnt_d;
            stray_q   <= stray_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        sum_d     = sum_q;
        err_d     = err_q;
        job_cnt_d = job_cnt_q;
        tmo_d     = (state_q == S_WAIT) ? tmo_q + TMO_W'(1) : '0;
        stray_d   = stray_q | (acc_finish && (state_q != S_WAIT));

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    len_d = req_len;
                    sum_d = '0;
                    err_d = 1'b0;
                    // A zero-length job never starts the accumulator.
                    state_d = (req_len == '0) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Finish is checked first so it wins over a coincident timeout.
                if (acc_finish) begin
                    sum_d   = acc_sum;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    sum_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    job_cnt_d = job_cnt_q + JCNT_W'(1);
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs come from state and registers only.
    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        acc_start = (state_q == S_ISSUE);
        busy      = (state_q != S_IDLE);
        acc_data  = (state_q != S_IDLE) ? len_q : '0;
        rsp_sum   = sum_q;
        rsp_err   = err_q;
        stray_fin = stray_q;
        job_cnt   = job_cnt_q;
    end

endmodule
